// File: rtl/layer_seq_pkg.sv
// -----------------------------------------------------------------------------
// layer_seq_pkg
//   Shared definitions for the layer sequencer:
//     - state_t      : sequencer FSM state encoding
//     - I_*          : bit positions of the fields inside the 34-bit core
//                      instruction word
//     - IDLE_INST    : instruction word driven whenever nothing is happening
//                      (both SRAMs deselected and write-disabled, all strobes 0)
// -----------------------------------------------------------------------------
package layer_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WLD,
    S_WPE,
    S_WGAP,
    S_XLD,
    S_EXE,
    S_DRAIN,
    S_ACC,
    S_DONE
  } state_t;

  localparam int INST_W       = 34;
  localparam int A_FIELD_W    = 11;

  localparam int I_ACC        = 33;
  localparam int I_CEN_PMEM   = 32;
  localparam int I_WEN_PMEM   = 31;
  localparam int I_A_PMEM_LSB = 20;
  localparam int I_CEN_XMEM   = 19;
  localparam int I_WEN_XMEM   = 18;
  localparam int I_A_XMEM_LSB = 7;
  localparam int I_OFIFO_RD   = 6;
  localparam int I_IFIFO_WR   = 5;
  localparam int I_IFIFO_RD   = 4;
  localparam int I_L0_RD      = 3;
  localparam int I_L0_WR      = 2;
  localparam int I_EXECUTE    = 1;
  localparam int I_LOAD       = 0;

  localparam logic [INST_W-1:0] IDLE_INST = 34'h1800C0000;

endpackage

// File: rtl/seq_addr_gen.sv
// -----------------------------------------------------------------------------
// seq_addr_gen
//   Combinational SRAM address generation for the layer sequencer. All sums
//   wrap modulo 2^ADDR_W.
//   Ports:
//     w_base, x_base, p_base : latched layer base addresses
//     kij                    : kernel position for weight / psum addressing
//     nij                    : pixels per kernel position (psum stride)
//     x_idx                  : inner counter for weight and activation reads
//     p_idx                  : pixel index for psum accesses
//     w_addr                 : w_base + kij*COL + x_idx
//     x_addr                 : x_base + x_idx
//     p_addr                 : p_base + kij*nij + p_idx
// -----------------------------------------------------------------------------
module seq_addr_gen #(
  parameter int COL    = 8,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 6
) (
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic [3:0]        kij,
  input  logic [5:0]        nij,
  input  logic [CNT_W-1:0]  x_idx,
  input  logic [CNT_W-1:0]  p_idx,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] p_addr
);

  // Sums are formed at 32 bits and truncated, which gives the modulo wrap.
  assign w_addr = ADDR_W'(32'(w_base) + 32'(kij) * 32'(COL) + 32'(x_idx));
  assign x_addr = ADDR_W'(32'(x_base) + 32'(x_idx));
  assign p_addr = ADDR_W'(32'(p_base) + 32'(kij) * 32'(nij) + 32'(p_idx));

endmodule

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//   Drives the 34-bit core instruction word through one convolution layer:
//   for every kernel position it loads weights into L0, pushes them into the
//   PE array, waits for propagation, loads activations, executes, and drains
//   the OFIFO into psum memory. Optionally finishes with an accumulation pass.
//
//   Build option: define SEQ_ACC_EN to enable the ACC state (psum read-back
//   with acc=1 after the last kernel position). Without it inst[33] is 0 and
//   the last DRAIN goes straight to DONE.
//
//   Ports:
//     clk          : clock, rising edge
//     reset        : synchronous, active-high
//     start        : one-cycle pulse, accepted only in IDLE
//     cfg_kij      : kernel positions (0 treated as 1)
//     cfg_nij      : pixels per kernel position (0 treated as 1)
//     cfg_w_base   : xmem weight base address
//     cfg_x_base   : xmem activation base address
//     cfg_p_base   : pmem psum base address
//     ofifo_valid  : OFIFO holds a full row
//     inst         : registered core instruction word
//     busy         : high from start acceptance through the DONE cycle
//     done         : one-cycle completion pulse
//
//   All outputs are registered decodes of the current state, so each output
//   cycle appears one clock after the state that produced it.
// -----------------------------------------------------------------------------
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int KIJ_MAX = 9,
  parameter int NIJ_MAX = 36,
  parameter int ADDR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        cfg_kij,
  input  logic [5:0]        cfg_nij,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_x_base,
  input  logic [ADDR_W-1:0] cfg_p_base,
  input  logic              ofifo_valid,
  output logic [33:0]       inst,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(COL + ROW + NIJ_MAX + 2);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;        // phase counter / DRAIN read count / ACC pixel
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;  // DRAIN pmem writes completed
  logic                wr_pend_q, wr_pend_d;// ofifo_rd issued last cycle -> write now
  logic [3:0]          kij_q, kij_d;        // current kernel position
  logic [3:0]          kij_cfg_q, kij_cfg_d;
  logic [5:0]          nij_cfg_q, nij_cfg_d;
  logic [ADDR_W-1:0]   w_base_q, w_base_d;
  logic [ADDR_W-1:0]   x_base_q, x_base_d;
  logic [ADDR_W-1:0]   p_base_q, p_base_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CNT_W-1:0]    nij_ext;
  logic [CNT_W-1:0]    nij_last;
  logic [3:0]          kij_last;
  logic [CNT_W-1:0]    p_idx;
  logic [ADDR_W-1:0]   w_addr, x_addr, p_addr;

  assign nij_ext  = CNT_W'(nij_cfg_q);
  assign nij_last = nij_ext - CNT_W'(1);
  assign kij_last = kij_cfg_q - 4'd1;

`ifdef SEQ_ACC_EN
  // ACC reuses cnt_q as the pixel index and kij_q as the kernel position.
  assign p_idx = (state_q == S_ACC) ? cnt_q : wr_cnt_q;
`else
  assign p_idx = wr_cnt_q;
`endif

  seq_addr_gen #(
    .COL    (COL),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .w_base (w_base_q),
    .x_base (x_base_q),
    .p_base (p_base_q),
    .kij    (kij_q),
    .nij    (nij_cfg_q),
    .x_idx  (cnt_q),
    .p_idx  (p_idx),
    .w_addr (w_addr),
    .x_addr (x_addr),
    .p_addr (p_addr)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_pend_d = 1'b0;
    kij_d     = kij_q;
    kij_cfg_d = kij_cfg_q;
    nij_cfg_d = nij_cfg_q;
    w_base_d  = w_base_q;
    x_base_d  = x_base_q;
    p_base_d  = p_base_q;
    inst_d    = IDLE_INST;
    busy_d    = (state_q != S_IDLE);
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Zero is treated as one; oversize values clamp to the array limits.
          if (cfg_kij == 4'd0)               kij_cfg_d = 4'd1;
          else if (cfg_kij > 4'(KIJ_MAX))    kij_cfg_d = 4'(KIJ_MAX);
          else                               kij_cfg_d = cfg_kij;
          if (cfg_nij == 6'd0)               nij_cfg_d = 6'd1;
          else if (cfg_nij > 6'(NIJ_MAX))    nij_cfg_d = 6'(NIJ_MAX);
          else                               nij_cfg_d = cfg_nij;
          w_base_d = cfg_w_base;
          x_base_d = cfg_x_base;
          p_base_d = cfg_p_base;
          kij_d    = 4'd0;
          cnt_d    = '0;
          state_d  = S_WLD;
        end
      end

      S_WLD: begin
        // COL reads, with the L0 write trailing each read by one cycle.
        if (cnt_q < CNT_W'(COL)) begin
          inst_d[I_CEN_XMEM] = 1'b0;
          inst_d[I_A_XMEM_LSB +: A_FIELD_W] = A_FIELD_W'(w_addr);
        end
        if (cnt_q != '0) inst_d[I_L0_WR] = 1'b1;
        if (cnt_q == CNT_W'(COL)) begin
          cnt_d   = '0;
          state_d = S_WPE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WPE: begin
        inst_d[I_L0_RD] = 1'b1;
        inst_d[I_LOAD]  = 1'b1;
        if (cnt_q == CNT_W'(COL - 1)) begin
          cnt_d   = '0;
          state_d = S_WGAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WGAP: begin
        // Idle cycles while weights ripple down the PE rows.
        if (cnt_q == CNT_W'(ROW - 1)) begin
          cnt_d   = '0;
          state_d = S_XLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_XLD: begin
        if (cnt_q < nij_ext) begin
          inst_d[I_CEN_XMEM] = 1'b0;
          inst_d[I_A_XMEM_LSB +: A_FIELD_W] = A_FIELD_W'(x_addr);
        end
        if (cnt_q != '0) inst_d[I_L0_WR] = 1'b1;
        if (cnt_q == nij_ext) begin
          cnt_d   = '0;
          state_d = S_EXE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_EXE: begin
        inst_d[I_L0_RD]   = 1'b1;
        inst_d[I_EXECUTE] = 1'b1;
        if (cnt_q == nij_last) begin
          cnt_d    = '0;
          wr_cnt_d = '0;
          state_d  = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DRAIN: begin
        // Reads are gated by ofifo_valid; each read becomes a psum write on
        // the following cycle, so the phase ends on the last write.
        if (ofifo_valid && (cnt_q < nij_ext)) begin
          inst_d[I_OFIFO_RD] = 1'b1;
          wr_pend_d          = 1'b1;
          cnt_d              = cnt_q + CNT_W'(1);
        end
        if (wr_pend_q) begin
          inst_d[I_CEN_PMEM] = 1'b0;
          inst_d[I_WEN_PMEM] = 1'b0;
          inst_d[I_A_PMEM_LSB +: A_FIELD_W] = A_FIELD_W'(p_addr);
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == nij_last) begin
            cnt_d = '0;
            if (kij_q == kij_last) begin
`ifdef SEQ_ACC_EN
              kij_d   = 4'd0;
              state_d = S_ACC;
`else
              state_d = S_DONE;
`endif
            end else begin
              kij_d   = kij_q + 4'd1;
              state_d = S_WLD;
            end
          end
        end
      end

`ifdef SEQ_ACC_EN
      S_ACC: begin
        // Kernel position is the inner loop so each output pixel's psums
        // arrive back to back.
        inst_d[I_ACC]      = 1'b1;
        inst_d[I_CEN_PMEM] = 1'b0;
        inst_d[I_A_PMEM_LSB +: A_FIELD_W] = A_FIELD_W'(p_addr);
        if (kij_q == kij_last) begin
          kij_d = 4'd0;
          if (cnt_q == nij_last) state_d = S_DONE;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          kij_d = kij_q + 4'd1;
        end
      end
`endif

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_cnt_q  <= '0;
      wr_pend_q <= 1'b0;
      kij_q     <= 4'd0;
      kij_cfg_q <= 4'd0;
      nij_cfg_q <= 6'd0;
      w_base_q  <= '0;
      x_base_q  <= '0;
      p_base_q  <= '0;
      inst_q    <= IDLE_INST;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_pend_q <= wr_pend_d;
      kij_q     <= kij_d;
      kij_cfg_q <= kij_cfg_d;
      nij_cfg_q <= nij_cfg_d;
      w_base_q  <= w_base_d;
      x_base_q  <= x_base_d;
      p_base_q  <= p_base_d;
      inst_q    <= inst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
//   Scoreboard bench: each start pushes the full list of expected SRAM
//   addresses and per-layer strobe totals; a monitor pops and compares on
//   every output event and closes the layer on the done pulse.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [33:0] IDLE_WORD = 34'h1800C0000;

`ifdef SEQ_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_kij = '0;
  logic [5:0]  cfg_nij = '0;
  logic [10:0] cfg_w_base = '0;
  logic [10:0] cfg_x_base = '0;
  logic [10:0] cfg_p_base = '0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        busy;
  logic        done;

  layer_sequencer #(
    .ROW(ROW), .COL(COL), .KIJ_MAX(9), .NIJ_MAX(36), .ADDR_W(11)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_kij    (cfg_kij),
    .cfg_nij    (cfg_nij),
    .cfg_w_base (cfg_w_base),
    .cfg_x_base (cfg_x_base),
    .cfg_p_base (cfg_p_base),
    .ofifo_valid(ofifo_valid),
    .inst       (inst),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kij;
    int nij;
    bit chk_len;
  } layer_t;

  int     checks = 0;
  int     failures = 0;
  int     layers_done = 0;
  int     xq[$];
  int     pq[$];
  int     aq[$];
  layer_t lq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    bit v_edge, r_edge, prev_xrd, prev_ofrd, after_done;
    bit xrd, pw, pr;
    int c_ld, c_ex, c_l0rd, c_l0wr, c_ofrd, c_busy, c_acc;
    layer_t L;
    prev_xrd = 0; prev_ofrd = 0; after_done = 0;
    c_ld = 0; c_ex = 0; c_l0rd = 0; c_l0wr = 0; c_ofrd = 0; c_busy = 0; c_acc = 0;
    forever begin
      @(posedge clk);
      v_edge = ofifo_valid;
      r_edge = reset;
      #1;
      if (r_edge) begin
        check("reset_inst", 64'(inst), 64'(IDLE_WORD));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        xq.delete(); pq.delete(); aq.delete(); lq.delete();
        prev_xrd = 0; prev_ofrd = 0; after_done = 0;
        c_ld = 0; c_ex = 0; c_l0rd = 0; c_l0wr = 0; c_ofrd = 0; c_busy = 0; c_acc = 0;
      end else begin
        xrd = !inst[19];
        pw  = !inst[32] && !inst[31];
        pr  = !inst[32] &&  inst[31];
        if (xrd) begin
          check("xmem_wen", 64'(inst[18]), 64'd1);
          if (xq.size() == 0) check("xmem_extra_read", 64'(inst[17:7]), 64'h7ff_ffff);
          else                check("xmem_addr", 64'(inst[17:7]), 64'(xq.pop_front()));
        end
        if (inst[2] || prev_xrd) check("l0_wr_lag", 64'(inst[2]), 64'(prev_xrd));
        if (pw || prev_ofrd)     check("pmem_wr_lag", 64'(pw), 64'(prev_ofrd));
        if (pw) begin
          if (pq.size() == 0) check("pmem_extra_write", 64'(inst[30:20]), 64'h7ff_ffff);
          else                check("pmem_wr_addr", 64'(inst[30:20]), 64'(pq.pop_front()));
        end
        if (pr || inst[33]) check("acc_read", 64'({inst[33], pr}), ACC_ON ? 64'd3 : 64'd0);
        if (pr && ACC_ON) begin
          if (aq.size() == 0) check("pmem_extra_read", 64'(inst[30:20]), 64'h7ff_ffff);
          else                check("pmem_rd_addr", 64'(inst[30:20]), 64'(aq.pop_front()));
        end
        if (inst[6]) check("ofifo_rd_needs_valid", 64'(v_edge), 64'd1);
        if (inst[0]) c_ld++;
        if (inst[1]) c_ex++;
        if (inst[3]) c_l0rd++;
        if (inst[2]) c_l0wr++;
        if (inst[6]) c_ofrd++;
        if (inst[33]) c_acc++;
        if (busy)    c_busy++;
        if (after_done) begin
          check("busy_after_done", 64'(busy), 64'd0);
          after_done = 0;
        end
        if (!busy && !done) check("idle_inst", 64'(inst), 64'(IDLE_WORD));
        if (done) begin
          check("done_with_busy", 64'(busy), 64'd1);
          if (lq.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            L = lq.pop_front();
            check("load_cycles",  64'(c_ld),   64'(L.kij * COL));
            check("exec_cycles",  64'(c_ex),   64'(L.kij * L.nij));
            check("l0_rd_cycles", 64'(c_l0rd), 64'(L.kij * (COL + L.nij)));
            check("l0_wr_cycles", 64'(c_l0wr), 64'(L.kij * (COL + L.nij)));
            check("ofifo_rd_cnt", 64'(c_ofrd), 64'(L.kij * L.nij));
            check("acc_cycles",   64'(c_acc),  ACC_ON ? 64'(L.kij * L.nij) : 64'd0);
            if (L.chk_len)
              check("layer_cycles", 64'(c_busy),
                    64'(L.kij * (2 * COL + ROW + 3 * L.nij + 3) +
                        (ACC_ON ? L.kij * L.nij : 0) + 1));
            check("xmem_left", 64'(xq.size()), 64'd0);
            check("pmem_wr_left", 64'(pq.size()), 64'd0);
            check("pmem_rd_left", 64'(aq.size()), 64'd0);
          end
          layers_done++;
          c_ld = 0; c_ex = 0; c_l0rd = 0; c_l0wr = 0; c_ofrd = 0; c_busy = 0; c_acc = 0;
          after_done = 1;
        end
        prev_xrd  = xrd;
        prev_ofrd = inst[6];
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // mode 0: ofifo_valid tied 1      1: random ofifo_valid
  // mode 2: 10-cycle valid gap in DRAIN
  // mode 3: start pulse + cfg churn mid-layer   4: reset during EXE
  task automatic run_layer(input int k_in, input int n_in, input int wb,
                           input int xb, input int pb, input int mode);
    layer_t L;
    int k, n, target, low_left;
    bit hit;
    k = (k_in == 0) ? 1 : k_in;
    n = (n_in == 0) ? 1 : n_in;
    @(negedge clk);
    start = 1'b1;
    cfg_kij = 4'(k_in);
    cfg_nij = 6'(n_in);
    cfg_w_base = 11'(wb);
    cfg_x_base = 11'(xb);
    cfg_p_base = 11'(pb);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < COL; i++) xq.push_back((wb + kk * COL + i) % 2048);
      for (int i = 0; i < n; i++)   xq.push_back((xb + i) % 2048);
      for (int i = 0; i < n; i++)   pq.push_back((pb + kk * n + i) % 2048);
    end
    if (ACC_ON)
      for (int nn = 0; nn < n; nn++)
        for (int kk = 0; kk < k; kk++) aq.push_back((pb + kk * n + nn) % 2048);
    L.kij = k;
    L.nij = n;
    L.chk_len = (mode == 0 || mode == 3);
    lq.push_back(L);
    ofifo_valid = 1'b1;
    target = layers_done + 1;
    hit = 0;
    low_left = 0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (layers_done >= target) break;
      case (mode)
        1: ofifo_valid = ($urandom_range(0, 3) != 0);
        2: begin
          if (!hit && inst[6]) begin
            hit = 1; ofifo_valid = 1'b0; low_left = 10;
          end else if (low_left > 0) begin
            low_left--;
            if (low_left == 0) ofifo_valid = 1'b1;
          end
        end
        3: begin
          start = (cyc == 20);
          cfg_kij = 4'($urandom_range(1, 9));
          cfg_nij = 6'($urandom_range(1, 36));
          cfg_w_base = 11'($urandom);
          cfg_x_base = 11'($urandom);
          cfg_p_base = 11'($urandom);
        end
        4: begin
          if (inst[1]) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
          end
        end
        default: ;
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    check("layer_done_seen", 64'(layers_done >= target), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : driver
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run_layer(1, 4, 100, 200, 300, 0);        // basic phase lengths
    run_layer(2, 36, 2000, 2040, 2040, 0);    // address wrap
    run_layer(3, 5, 17, 900, 64, 2);          // DRAIN stall
    run_layer(4, 12, 10, 20, 30, 4);          // reset in EXE
    run_layer(2, 6, 500, 600, 700, 0);        // full layer after reset
    run_layer(3, 7, 1, 2, 3, 3);              // ignored start / cfg churn
    run_layer(0, 0, 2047, 2047, 2047, 0);     // zero config -> 1
    run_layer(9, 16, 123, 456, 789, 0);       // largest kij
    for (int t = 0; t < 5; t++)
      run_layer($urandom_range(0, 9), $urandom_range(0, 36), $urandom_range(0, 2047),
                $urandom_range(0, 2047), $urandom_range(0, 2047), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  ROW, 8, PE rows / L0 lanes
  COL, 8, PE columns / OFIFO lanes
  KIJ_MAX, 9, max kernel positions
  NIJ_MAX, 36, max input pixels per kernel position
  ADDR_W, 11, SRAM address width
REQ-002 Ports, one per line (name direction width meaning):
  clk  input  1  single clock, rising edge
  reset  input  1  synchronous, active-high
  start  input  1  one-cycle pulse; accepted only in IDLE
  cfg_kij  input  4  kernel positions, 1..KIJ_MAX
  cfg_nij  input  6  input pixels per position, 1..NIJ_MAX
  cfg_w_base  input  ADDR_W  xmem weight base
  cfg_x_base  input  ADDR_W  xmem activation base
  cfg_p_base  input  ADDR_W  pmem psum base
  ofifo_valid  input  1  OFIFO holds a full row
  inst  output  34  core instruction word (fields below)
  busy  output  1  high from start acceptance until DONE exit
  done  output  1  one-cycle pulse at layer completion
REQ-003 inst fields: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load; inst is registered.

Function
REQ-004 Idle inst value SHALL be 34'h1800C0000 (both CEN/WEN high, all else 0).
REQ-005 cfg_* SHALL be latched on accepted start; start while busy SHALL be ignored; cfg_kij/cfg_nij of 0 SHALL be treated as 1.
REQ-006 FSM states: IDLE, WLD, WPE, WGAP, XLD, EXE, DRAIN, ACC, DONE; per kij loop WLD->WPE->WGAP->XLD->EXE->DRAIN, then next kij or ACC/DONE.
REQ-007 WLD: COL cycles of xmem read (CEN_xmem=0, WEN_xmem=1) at cfg_w_base+kij*COL+i; l0_wr high one cycle after each read (COL+1 cycles total).
REQ-008 WPE: COL cycles with l0_rd=1, load=1; WGAP: ROW idle cycles for weight propagation.
REQ-009 XLD: cfg_nij xmem reads at cfg_x_base+i, l0_wr lagging by one cycle (cfg_nij+1 cycles).
REQ-010 EXE: cfg_nij cycles with l0_rd=1, execute=1.
REQ-011 DRAIN: ofifo_rd=1 only in cycles where ofifo_valid=1; pmem write (CEN_pmem=0, WEN_pmem=0) one cycle after each ofifo_rd at cfg_p_base+kij*cfg_nij+n; exits after cfg_nij writes; stalls indefinitely without ofifo_valid.
REQ-012 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-013 DONE: one cycle, done=1, busy=0 next cycle, return to IDLE.

Reset
REQ-014 reset asserted at any clk edge, including mid-layer, SHALL force IDLE, inst=34'h1800C0000, busy=0, done=0, clear all counters and latched cfg on the same edge.

Configuration
REQ-015 Macro SEQ_ACC_EN defined: after last kij, ACC state issues cfg_kij*cfg_nij pmem reads (CEN_pmem=0, WEN_pmem=1) in kij-major order per output pixel with acc=1 on each read cycle, then DONE.
REQ-016 SEQ_ACC_EN undefined: ACC state absent, inst[33] tied 0, last DRAIN goes directly to DONE.

Structure
REQ-017 Shared package layer_seq_pkg holds the state enum, inst field bit positions, and the idle inst constant.
REQ-018 One sub-module, seq_addr_gen, produces xmem/pmem addresses from base, kij and inner counter; FSM stays in layer_sequencer.

Verification
REQ-019 Reset mid-EXE -> next cycle inst=34'h1800C0000, busy=0; new start runs full layer.
REQ-020 cfg_kij=1, cfg_nij=4, ofifo_valid tied 1, macro off -> WLD 9, WPE 8, WGAP 8, XLD 5, EXE 4, DRAIN 5 cycles, done pulse once, A_pmem writes base..base+3.
REQ-021 cfg_kij=2, cfg_nij=36, cfg_p_base=2040 -> second-kij pmem addresses wrap 2040+36.. mod 2048 starting at 28.
REQ-022 ofifo_valid low 10 cycles inside DRAIN -> no ofifo_rd or pmem write in those cycles, write count still cfg_nij.
REQ-023 SEQ_ACC_EN, cfg_kij=9, cfg_nij=16 -> exactly 144 acc=1 cycles with pmem reads, then done.
REQ-024 start pulsed during busy -> ignored; cfg changes mid-layer have no effect.
